// File: rtl/decode_issue_ctrl_if.sv
// Handshake and bus bundle between fetch, the external decoder, the execution
// units, the trap handler and the decode/issue controller.
interface decode_issue_ctrl_if #(
    parameter int XLEN = 32
);
    // Fetch side
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;

    // Combinational decoder loop
    logic [17:0]     dec_instr;
    logic [15:0]     dec_decode;

    // Execution unit handshakes
    logic            alu_valid;
    logic            alu_ready;
    logic            lsu_valid;
    logic            lsu_ready;
    logic            csr_valid;
    logic            csr_ready;
    logic            lsu_done;

    // Issue payload
    logic [15:0]     issue_decode;
    logic [31:0]     issue_instr;
    logic [XLEN-1:0] issue_pc;

    // Redirect and exception
    logic            flush;
    logic            exc_valid;
    logic [1:0]      exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic            exc_ack;

    // Controller view
    modport master (
        input  if_valid, if_instr, if_pc, dec_decode,
               alu_ready, lsu_ready, csr_ready, lsu_done, flush, exc_ack,
        output if_ready, dec_instr, alu_valid, lsu_valid, csr_valid,
               issue_decode, issue_instr, issue_pc, exc_valid, exc_cause, exc_pc
    );

    // Environment view (fetch, decoder, units, trap handler)
    modport slave (
        output if_valid, if_instr, if_pc, dec_decode,
               alu_ready, lsu_ready, csr_ready, lsu_done, flush, exc_ack,
        input  if_ready, dec_instr, alu_valid, lsu_valid, csr_valid,
               issue_decode, issue_instr, issue_pc, exc_valid, exc_cause, exc_pc
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: single-entry ID/EX holding register, routing of the
// decoded instruction to ALU/LSU/CSR, FENCE/CSR serialisation against
// outstanding LSU operations, and conversion of faulting decodes into an
// exception request.
module decode_issue_ctrl #(
    parameter int XLEN         = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    decode_issue_ctrl_if.master  io
);
    localparam int               CNT_W   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_TRAP} state_e;
    typedef enum logic [2:0] {CL_ALU, CL_LSU, CL_CSR, CL_FENCE, CL_EXC} class_e;

    state_e            state_q, state_d;
    logic              hold_valid_q, hold_valid_d;
    logic [31:0]       hold_instr_q, hold_instr_d;
    logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              exc_valid_q, exc_valid_d;
    logic [1:0]        exc_cause_q, exc_cause_d;
    logic [XLEN-1:0]   exc_pc_q, exc_pc_d;

    class_e            cls;
    logic [1:0]        cls_cause;
    logic              issue_ok;
    logic              alu_valid, lsu_valid, csr_valid;
    logic              fence_retire, retire, if_ready, accept;
    logic              lsu_fire, lsu_done_eff;

    // Decoder fields used for classification
    logic [1:0]        dec_unit;
    logic              dec_csr, dec_fence, dec_ecall, dec_ebreak, dec_illegal;

    assign dec_unit    = io.dec_decode[15:14];
    assign dec_csr     = io.dec_decode[5];
    assign dec_fence   = io.dec_decode[4];
    assign dec_ecall   = io.dec_decode[3];
    assign dec_ebreak  = io.dec_decode[2];
    assign dec_illegal = io.dec_decode[1];

    // Classify the held instruction; faults outrank serialisation and routing
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        cls       = CL_EXC;
        cls_cause = 2'd0;
        if (dec_illegal) begin
            cls       = CL_EXC;
            cls_cause = 2'd0;
        end else if (dec_ecall) begin
            cls       = CL_EXC;
            cls_cause = 2'd1;
        end else if (dec_ebreak) begin
            cls       = CL_EXC;
            cls_cause = 2'd2;
        end else if (dec_fence) begin
            cls = CL_FENCE;
        end else if (dec_csr) begin
            cls = CL_CSR;
        end else if (dec_unit == 2'd0) begin
            cls = CL_ALU;
        end else if (dec_unit == 2'd1) begin
            cls = CL_LSU;
        end else begin
            cls       = CL_EXC;
            cls_cause = 2'd0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // FSM next state: trap on faults, drain a FENCE while LSU ops are outstanding
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (!io.flush && hold_valid_q) begin
                    if (cls == CL_EXC)                                state_d = ST_TRAP;
                    else if (cls == CL_FENCE && inflight_q != '0)     state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (io.flush || inflight_q == '0) state_d = ST_RUN;
            ST_TRAP:  if (io.exc_ack)                   state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM outputs: unit valids, FENCE retire and fetch back-pressure
    always_comb begin
        issue_ok     = (state_q == ST_RUN) && hold_valid_q && !io.flush;
        alu_valid    = issue_ok && (cls == CL_ALU);
        lsu_valid    = issue_ok && (cls == CL_LSU) && (inflight_q != MAX_CNT);
        csr_valid    = issue_ok && (cls == CL_CSR) && (inflight_q == '0);
        // In DRAIN the held instruction is always the FENCE that caused it
        fence_retire = !io.flush && hold_valid_q && (cls == CL_FENCE) && (inflight_q == '0)
                       && (state_q == ST_RUN || state_q == ST_DRAIN);
        lsu_fire     = lsu_valid && io.lsu_ready;
        retire       = (alu_valid && io.alu_ready) || lsu_fire
                       || (csr_valid && io.csr_ready) || fence_retire;
        if_ready     = (state_q == ST_RUN) && !io.flush && (!hold_valid_q || retire);
        accept       = if_ready && io.if_valid;
    end

    // Holding register, exception capture and LSU in-flight accounting
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        exc_valid_d  = exc_valid_q;
        exc_cause_d  = exc_cause_q;
        exc_pc_d     = exc_pc_q;
        inflight_d   = inflight_q;

        if (state_q == ST_TRAP) begin
            // Flush is ignored here; only the trap handler releases the stage
            if (io.exc_ack) begin
                hold_valid_d = 1'b0;
                exc_valid_d  = 1'b0;
            end
        end else if (io.flush) begin
            hold_valid_d = 1'b0;
        end else if (accept) begin
            hold_valid_d = 1'b1;
            hold_instr_d = io.if_instr;
            hold_pc_d    = io.if_pc;
        end else if (retire) begin
            hold_valid_d = 1'b0;
        end

        if (state_q == ST_RUN && hold_valid_q && !io.flush && cls == CL_EXC) begin
            exc_valid_d = 1'b1;
            exc_cause_d = cls_cause;
            exc_pc_d    = hold_pc_q;
        end

        // A completion with nothing outstanding is spurious and dropped
        lsu_done_eff = io.lsu_done && (inflight_q != '0);
        if (lsu_fire && !lsu_done_eff)      inflight_d = inflight_q + 1'b1;
        else if (!lsu_fire && lsu_done_eff) inflight_d = inflight_q - 1'b1;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            inflight_q   <= '0;
            exc_valid_q  <= 1'b0;
            exc_cause_q  <= 2'd0;
            exc_pc_q     <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            inflight_q   <= inflight_d;
            exc_valid_q  <= exc_valid_d;
            exc_cause_q  <= exc_cause_d;
            exc_pc_q     <= exc_pc_d;
        end
    end

    assign io.if_ready     = if_ready;
    assign io.alu_valid    = alu_valid;
    assign io.lsu_valid    = lsu_valid;
    assign io.csr_valid    = csr_valid;
    assign io.dec_instr    = {hold_instr_q[31:25], hold_instr_q[20], hold_instr_q[14:12], hold_instr_q[6:0]};
    assign io.issue_decode = io.dec_decode;
    assign io.issue_instr  = hold_instr_q;
    assign io.issue_pc     = hold_pc_q;
    assign io.exc_valid    = exc_valid_q;
    assign io.exc_cause    = exc_cause_q;
    assign io.exc_pc       = exc_pc_q;
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: a small reference decoder closes
// the dec_instr/dec_decode loop, a vector table covers single-instruction
// routing, and directed sequences cover the multi-cycle corner cases.
module tb_decode_issue_ctrl;
    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_CSRRW = 32'h34029073;
    localparam logic [31:0] I_FENCE = 32'h0FF0000F;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_EBRK  = 32'h00100073;
    localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;
    localparam logic [31:0] I_AMO   = 32'h0020A02F;
    localparam logic [31:0] I_FP    = 32'h00000053;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exp_alu;
        logic        exp_lsu;
        logic        exp_csr;
        logic        exp_rdy;
        logic        exp_exc;
        logic [1:0]  exp_cause;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [11];

    decode_issue_ctrl_if #(.XLEN(32)) bus ();

    decode_issue_ctrl #(.XLEN(32), .MAX_INFLIGHT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decoder: {unit, sub_unit, sel, imm, csr, fence, ecall, ebreak, illegal, calc_j}
    function automatic logic [15:0] ref_decode(input logic [17:0] d);
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       b20;
        logic [1:0] unit;
        logic [2:0] sub;
        logic [3:0] sel;
        logic       imm, csr, fence, ecall, ebreak, illegal;
        op = d[6:0]; f3 = d[9:7]; b20 = d[10]; f7 = d[17:11];
        unit = 2'd0; sub = 3'd0; sel = {1'b0, f3}; imm = 1'b0; csr = 1'b0;
        fence = 1'b0; ecall = 1'b0; ebreak = 1'b0; illegal = 1'b0;
        case (op)
            7'b0010011: begin sub = 3'd2; imm = 1'b1; end
            7'b0110011: begin sub = 3'd1; sel = {f7[5], f3}; end
            7'b0000011: begin unit = 2'd1; imm = 1'b1; end
            7'b0100011: begin unit = 2'd1; sub = 3'd1; imm = 1'b1; end
            7'b0001111: fence = 1'b1;
            7'b1110011: begin
                if (f3 != 3'd0)              begin unit = 2'd2; csr = 1'b1; end
                else if (f7 == 7'd0 && !b20) ecall = 1'b1;
                else if (f7 == 7'd0 && b20)  ebreak = 1'b1;
                else                         illegal = 1'b1;
            end
            7'b0101111: unit = 2'd2;
            7'b1010011: unit = 2'd3;
            default:    illegal = 1'b1;
        endcase
        return {unit, sub, sel, imm, csr, fence, ecall, ebreak, illegal, 1'b0};
    endfunction

    always_comb bus.dec_decode = ref_decode(bus.dec_instr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_valid  = 1'b0;
        bus.if_instr  = '0;
        bus.if_pc     = '0;
        bus.alu_ready = 1'b0;
        bus.lsu_ready = 1'b0;
        bus.csr_ready = 1'b0;
        bus.lsu_done  = 1'b0;
        bus.flush     = 1'b0;
        bus.exc_ack   = 1'b0;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc    = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{I_ADDI,  32'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{I_ADD,   32'h1004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{I_LW,    32'h1008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{I_SW,    32'h100C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{I_CSRRW, 32'h1010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[5]  = '{I_FENCE, 32'h1014, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[6]  = '{I_ECALL, 32'h1018, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[7]  = '{I_EBRK,  32'h101C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        vecs[8]  = '{I_ONES,  32'h1020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[9]  = '{I_AMO,   32'h1024, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[10] = '{I_FP,    32'h1028, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};

        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        #3;
        check("rst_if_ready",  32'(bus.if_ready),  32'd1);
        check("rst_alu_valid", 32'(bus.alu_valid), 32'd0);
        check("rst_lsu_valid", 32'(bus.lsu_valid), 32'd0);
        check("rst_csr_valid", 32'(bus.csr_valid), 32'd0);
        check("rst_exc_valid", 32'(bus.exc_valid), 32'd0);
        check("rst_exc_cause", 32'(bus.exc_cause), 32'd0);
        check("rst_exc_pc",    bus.exc_pc,         32'd0);
        check("rst_issue_ins", bus.issue_instr,    32'd0);
        check("rst_issue_pc",  bus.issue_pc,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table: one instruction from idle, held with all readies low, then released
        foreach (vecs[i]) begin
            present(vecs[i].instr, vecs[i].pc);
            #1;
            check("vec_accept_rdy", 32'(bus.if_ready), 32'd1);
            tick();
            bus.if_valid = 1'b0;
            #1;
            check("vec_alu_valid", 32'(bus.alu_valid), 32'(vecs[i].exp_alu));
            check("vec_lsu_valid", 32'(bus.lsu_valid), 32'(vecs[i].exp_lsu));
            check("vec_csr_valid", 32'(bus.csr_valid), 32'(vecs[i].exp_csr));
            check("vec_if_ready",  32'(bus.if_ready),  32'(vecs[i].exp_rdy));
            check("vec_exc_early", 32'(bus.exc_valid), 32'd0);
            check("vec_issue_pc",  bus.issue_pc,       vecs[i].pc);
            tick();
            check("vec_alu_hold",  32'(bus.alu_valid), 32'(vecs[i].exp_alu));
            check("vec_lsu_hold",  32'(bus.lsu_valid), 32'(vecs[i].exp_lsu));
            check("vec_csr_hold",  32'(bus.csr_valid), 32'(vecs[i].exp_csr));
            check("vec_rdy_hold",  32'(bus.if_ready),  32'(vecs[i].exp_rdy));
            check("vec_exc_valid", 32'(bus.exc_valid), 32'(vecs[i].exp_exc));
            if (vecs[i].exp_exc) begin
                check("vec_exc_cause", 32'(bus.exc_cause), 32'(vecs[i].exp_cause));
                check("vec_exc_pc",    bus.exc_pc,         vecs[i].pc);
            end
            bus.alu_ready = 1'b1; bus.lsu_ready = 1'b1; bus.csr_ready = 1'b1; bus.exc_ack = 1'b1;
            tick();
            idle_inputs();
            bus.lsu_done = 1'b1;
            tick();
            bus.lsu_done = 1'b0;
            #1;
            check("vec_idle_rdy", 32'(bus.if_ready),  32'd1);
            check("vec_idle_exc", 32'(bus.exc_valid), 32'd0);
        end

        // ADDI decode fields and back-to-back ALU throughput
        bus.alu_ready = 1'b1;
        present(I_ADDI, 32'h8000);
        tick();
        present(I_ADD, 32'h8004);
        #1;
        check("tp_alu_valid0", 32'(bus.alu_valid), 32'd1);
        check("tp_if_ready0",  32'(bus.if_ready),  32'd1);
        check("addi_dec_hi",   32'(bus.issue_decode[15:7]), 32'h020);
        check("addi_dec_imm",  32'(bus.issue_decode[6]),    32'd1);
        tick();
        bus.if_valid = 1'b0;
        #1;
        check("tp_alu_valid1", 32'(bus.alu_valid), 32'd1);
        check("tp_issue_pc1",  bus.issue_pc,       32'h8004);
        tick();
        idle_inputs();

        // LSU saturation: four LW in flight stall the fifth
        bus.lsu_ready = 1'b1;
        bus.if_valid  = 1'b1;
        bus.if_instr  = I_LW;
        for (int i = 0; i < 5; i++) begin
            bus.if_pc = 32'h2000 + 32'(4 * i);
            tick();
        end
        bus.if_pc = 32'h2014;
        #1;
        check("sat_lsu_valid", 32'(bus.lsu_valid), 32'd0);
        check("sat_if_ready",  32'(bus.if_ready),  32'd0);
        check("sat_issue_pc",  bus.issue_pc,       32'h2010);
        tick();
        check("sat_lsu_still", 32'(bus.lsu_valid), 32'd0);
        bus.lsu_done = 1'b1;
        tick();
        bus.lsu_done = 1'b0;
        #1;
        check("sat_lsu_go",    32'(bus.lsu_valid), 32'd1);
        check("sat_if_rdy_go", 32'(bus.if_ready),  32'd1);
        tick();
        bus.if_valid = 1'b0;
        #1;
        check("sat_full_again", 32'(bus.lsu_valid), 32'd0);
        check("sat_issue_pc5",  bus.issue_pc,       32'h2014);
        bus.lsu_done = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        idle_inputs();
        // Extra done at zero must not underflow: CSR issues at once
        bus.csr_ready = 1'b0;
        present(I_CSRRW, 32'h2100);
        tick();
        bus.if_valid = 1'b0;
        #1;
        check("underflow_csr", 32'(bus.csr_valid), 32'd1);
        bus.csr_ready = 1'b1;
        tick();
        idle_inputs();

        // FENCE behind an outstanding LW drains, then retires silently
        bus.lsu_ready = 1'b1;
        present(I_LW, 32'h3000);
        tick();
        present(I_FENCE, 32'h3004);
        tick();
        idle_inputs();
        #1;
        check("fence_run_rdy", 32'(bus.if_ready), 32'd0);
        tick();
        check("drain_if_ready", 32'(bus.if_ready),  32'd0);
        check("drain_alu",      32'(bus.alu_valid), 32'd0);
        check("drain_lsu",      32'(bus.lsu_valid), 32'd0);
        check("drain_csr",      32'(bus.csr_valid), 32'd0);
        bus.lsu_done = 1'b1;
        tick();
        bus.lsu_done = 1'b0;
        #1;
        check("retire_if_ready", 32'(bus.if_ready),  32'd0);
        check("retire_no_valid", 32'({bus.alu_valid, bus.lsu_valid, bus.csr_valid}), 32'd0);
        tick();
        present(I_ADDI, 32'h3008);
        #1;
        check("post_fence_rdy", 32'(bus.if_ready), 32'd1);
        tick();
        bus.if_valid = 1'b0;
        #1;
        check("post_fence_alu", 32'(bus.alu_valid), 32'd1);
        check("post_fence_pc",  bus.issue_pc,       32'h3008);
        bus.alu_ready = 1'b1;
        tick();
        idle_inputs();

        // CSR waits for the outstanding LW to complete
        bus.lsu_ready = 1'b1;
        present(I_LW, 32'h4000);
        tick();
        present(I_CSRRW, 32'h4004);
        tick();
        idle_inputs();
        bus.csr_ready = 1'b1;
        #1;
        check("csr_blocked0", 32'(bus.csr_valid), 32'd0);
        tick();
        check("csr_blocked1", 32'(bus.csr_valid), 32'd0);
        bus.lsu_done = 1'b1;
        tick();
        bus.lsu_done = 1'b0;
        #1;
        check("csr_released", 32'(bus.csr_valid), 32'd1);
        check("csr_issue_pc", bus.issue_pc,       32'h4004);
        tick();
        bus.csr_ready = 1'b0;
        #1;
        check("csr_done_valid", 32'(bus.csr_valid), 32'd0);
        check("csr_done_rdy",   32'(bus.if_ready),  32'd1);

        // Exceptions held without ack (flush in TRAP is ignored), then acked
        for (int k = 0; k < 2; k++) begin
            logic [31:0] ins;
            logic [31:0] pc;
            logic [1:0]  cause;
            ins   = (k == 0) ? I_ECALL : I_ONES;
            pc    = (k == 0) ? 32'h6000 : 32'h6100;
            cause = (k == 0) ? 2'd1 : 2'd0;
            present(ins, pc);
            tick();
            bus.if_valid = 1'b0;
            tick();
            for (int c = 0; c < 3; c++) begin
                bus.flush = (c == 1);
                #1;
                check("trap_exc_valid", 32'(bus.exc_valid), 32'd1);
                check("trap_exc_cause", 32'(bus.exc_cause), 32'(cause));
                check("trap_exc_pc",    bus.exc_pc,         pc);
                check("trap_if_ready",  32'(bus.if_ready),  32'd0);
                tick();
            end
            bus.flush   = 1'b0;
            bus.exc_ack = 1'b1;
            tick();
            bus.exc_ack = 1'b0;
            #1;
            check("ack_exc_valid", 32'(bus.exc_valid), 32'd0);
            check("ack_if_ready",  32'(bus.if_ready),  32'd1);
        end

        // Flush kills the held ADD, blocks capture, keeps inflight
        bus.lsu_ready = 1'b1;
        present(I_LW, 32'h5000);
        tick();
        present(I_ADD, 32'h5004);
        tick();
        idle_inputs();
        #1;
        check("fl_alu_before", 32'(bus.alu_valid), 32'd1);
        tick();
        bus.flush = 1'b1;
        present(I_ADDI, 32'h5008);
        #1;
        check("fl_alu_supp", 32'(bus.alu_valid), 32'd0);
        check("fl_if_ready", 32'(bus.if_ready),  32'd0);
        tick();
        idle_inputs();
        #1;
        check("fl_hold_clr", 32'(bus.alu_valid), 32'd0);
        check("fl_empty_rdy", 32'(bus.if_ready), 32'd1);
        bus.csr_ready = 1'b1;
        present(I_CSRRW, 32'h500C);
        tick();
        bus.if_valid = 1'b0;
        #1;
        check("fl_inflight_kept", 32'(bus.csr_valid), 32'd0);
        bus.lsu_done = 1'b1;
        tick();
        bus.lsu_done = 1'b0;
        #1;
        check("fl_csr_after_done", 32'(bus.csr_valid), 32'd1);
        tick();
        idle_inputs();

        // Asynchronous reset in the middle of TRAP
        present(I_ECALL, 32'h7000);
        tick();
        bus.if_valid = 1'b0;
        tick();
        check("mid_trap_exc", 32'(bus.exc_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_exc",   32'(bus.exc_valid), 32'd0);
        check("async_rst_rdy",   32'(bus.if_ready),  32'd1);
        check("async_rst_excpc", bus.exc_pc,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_rdy", 32'(bus.if_ready),  32'd1);
        check("post_rst_exc", 32'(bus.exc_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Decode/issue stage controller between the fetch stage and the execution units. It captures fetched instructions into a single-entry ID/EX holding register, drives the combinational `decoder_PG` and routes each decoded instruction to the ALU, LSU or CSR unit with valid/ready handshakes. It serialises FENCE and CSR instructions against outstanding LSU operations and converts ILLEGAL/ECALL/EBREAK decodes into an exception request.

## Interface
Parameters:
- `XLEN`, 32, width of PC and instruction word.
- `MAX_INFLIGHT`, 4, maximum number of outstanding LSU operations. The counter is `$clog2(MAX_INFLIGHT+1)` bits wide.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `if_valid`  in  1  fetch presents an instruction.
- `if_ready`  out  1  controller accepts the instruction this cycle.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  XLEN  PC of `if_instr`.
- `dec_instr`  out  18  to the decoder: {hold_instr[31:25], hold_instr[20], hold_instr[14:12], hold_instr[6:0]}.
- `dec_decode`  in  16  from the decoder: {unit[15:14], sub_unit[13:11], sel[10:7], imm[6], csr[5], fence[4], ecall[3], ebreak[2], illegal[1], calc_j[0]}.
- `alu_valid` / `alu_ready`  out / in  1 / 1  ALU issue handshake.
- `lsu_valid` / `lsu_ready`  out / in  1 / 1  LSU issue handshake.
- `csr_valid` / `csr_ready`  out / in  1 / 1  CSR issue handshake.
- `lsu_done`  in  1  one-cycle pulse; an LSU operation has completed.
- `issue_decode`  out  16  `dec_decode` of the held instruction.
- `issue_instr`  out  32  held instruction.
- `issue_pc`  out  XLEN  held PC.
- `flush`  in  1  branch/jump redirect; kills the held instruction.
- `exc_valid`  out  1  exception request; held until acknowledged.
- `exc_cause`  out  2  0 = illegal, 1 = ecall, 2 = ebreak.
- `exc_pc`  out  XLEN  PC of the faulting instruction.
- `exc_ack`  in  1  trap handler accepts the exception.

## Operation
- State: `hold_valid`, `hold_instr`, `hold_pc`, FSM {RUN, DRAIN, TRAP}, `inflight` counter.
- Classification of the held instruction uses this priority:
  1. `illegal` → exception, cause 0.
  2. `ecall` → exception, cause 1.
  3. `ebreak` → exception, cause 2.
  4. `fence` → serialise.
  5. `csr` → CSR unit.
  6. `unit == 0` → ALU.
  7. `unit == 1` → LSU.
  8. `unit == 2` or `unit == 3` without the `csr` flag → exception, cause 0.
- Exactly one of `alu_valid`/`lsu_valid`/`csr_valid` is asserted, and only when `hold_valid` is set, the state is RUN and the class matches. Fire = valid && ready of that unit.
- LSU issue is blocked while `inflight == MAX_INFLIGHT`.
- CSR issue is blocked until `inflight == 0`.
- FSM transitions:
  - RUN → DRAIN: a held FENCE and `inflight != 0`. A FENCE with `inflight == 0` retires immediately, clearing `hold_valid` without any unit valid.
  - DRAIN → RUN: when `inflight == 0`. The FENCE retires that cycle.
  - RUN → TRAP: a held exception class. `exc_valid = 1` and `exc_cause`/`exc_pc` are registered on entry. No unit valid is asserted.
  - TRAP → RUN: on `exc_ack`. `exc_valid` drops and `hold_valid` clears.
- `if_ready = (state == RUN) && !flush && (!hold_valid || retire)`, where retire = unit fire or FENCE retire. An accepted instruction loads the holding register at the edge.
- `inflight`: +1 on LSU fire, −1 on `lsu_done`, unchanged when both occur in the same cycle. `lsu_done` at `inflight == 0` is ignored.
- `flush` in RUN or DRAIN:
  - clears `hold_valid`;
  - returns the FSM to RUN;
  - blocks capture of `if_instr` that cycle;
  - suppresses every unit valid;
  - leaves `inflight` unchanged.
- `flush` in TRAP is ignored.

## Timing
- Reset (asynchronous, `rst_n = 0`) forces:
  - state = RUN, `hold_valid = 0`, `inflight = 0`;
  - `exc_valid = 0`, `exc_cause = 0`, `exc_pc = 0`;
  - `hold_instr = 0`, `hold_pc = 0`;
  - all unit valids = 0, `if_ready = 1`.
- Reset asserted mid-operation discards the held instruction and any pending exception immediately.
- Latency: an instruction accepted at edge N presents its unit valid in cycle N+1, combinational from the registered hold through the decoder.
- Throughput is 1 instruction/cycle when the target unit ready is held high (back-to-back retire plus capture).
- Handshake rules:
  - Once asserted, a unit valid and `issue_*` stay stable until fire or flush.
  - `exc_valid` stays stable until `exc_ack`.
- `exc_valid` asserts the cycle after the exception instruction is held, one cycle of registered FSM entry.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) with `alu_ready = 1`: `alu_valid = 1` the cycle after acceptance; `issue_decode[15:7]` = unit 0, sub_unit 2, sel 0; imm = 1.
- 4 × LW with `lsu_ready = 1` and no `lsu_done`, then a fifth LW: the fifth is stalled with `lsu_valid = 0` and `if_ready = 0`. One `lsu_done` pulse → the fifth issues the next cycle and `inflight` returns to 4.
- LW issued, then FENCE (0x0FF0000F): FSM enters DRAIN and `if_ready = 0`. `lsu_done` pulse → the FENCE retires with no unit valid, and the next instruction is accepted.
- CSRRW (0x34029073) with `inflight = 1`: `csr_valid = 0` until `lsu_done`, then `csr_valid = 1`.
- ECALL (0x00000073): `exc_valid = 1`, `exc_cause = 1`, `exc_pc` = its PC, held for 3 cycles without ack. `exc_ack` → `exc_valid = 0` and `if_ready = 1`. Repeat with 0xFFFFFFFF → `exc_cause = 0`.
- Flush and reset interactions:
  - Held ADD with `alu_ready = 0`, then `flush` together with `if_valid`: `hold_valid` clears, the incoming instruction is not captured, and `inflight` is unchanged.
  - `rst_n` pulsed low mid-TRAP: `exc_valid` drops to 0 asynchronously.
